bus_arb_mux: RTL and testbench
==============================

Name: bus_arb_mux

Overview:
- Parametrised N:1 bus multiplexer with a registered output stage and per-channel valid/ready handshakes.
- Selects one of NUM_IN producer buses, either by an explicit select or by round-robin arbitration, and presents the winner on a single registered output bus.
- Sits between multiple requesters (e.g. writeback sources, memory ports) and a single shared consumer.

Parameters:
- WIDTH, 64, data bus width in bits.
- NUM_IN, 8, number of input channels; must be >= 2 and need not be a power of 2.
- SELW, $clog2(NUM_IN), derived localparam; width of the select and source-ID fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- in_data  input  [NUM_IN-1:0][WIDTH-1:0]  packed input buses, channel i at index i.
- in_valid  input  NUM_IN  per-channel request.
- in_ready  output  NUM_IN  per-channel accept; at most one bit high.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_src  output  SELW  channel index that produced out_data.

Behaviour:
- Reset (reset = 0, asynchronous): out_valid = 0, out_data = 0, out_src = 0, rr_ptr = NUM_IN-1 (channel 0 has first priority). in_ready is forced to all-zero while reset is low.
- load_en = !out_valid || out_ready. The output register may load only when load_en = 1.
- Grant in mode 0:
  - g = sel if sel < NUM_IN and in_valid[sel] = 1; otherwise there is no grant.
  - Other channels are never granted, even if valid.
  - sel >= NUM_IN yields no grant.
- Grant in mode 1:
  - g = first channel with in_valid set, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN, wrapping past NUM_IN-1 to 0.
  - If no channel is valid, there is no grant.
- in_ready[g] = load_en when a grant exists; all other in_ready bits = 0. in_ready is combinational from in_valid, mode, sel, rr_ptr, out_valid and out_ready.
- Accept = grant exists && load_en. On the next clk edge after an accept:
  - out_data <= in_data[g]
  - out_src <= g
  - out_valid <= 1
  - rr_ptr <= g (rr_ptr updates in both modes)
- load_en = 1 with no grant: out_valid <= 0 and rr_ptr holds. out_data and out_src hold their last values; their content is don't-care while out_valid = 0.
- Stall (out_valid = 1, out_ready = 0): out_data, out_src, out_valid and rr_ptr all hold; every in_ready = 0.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat per cycle when out_ready is held high. No bubble on simultaneous drain and load.
- Mode or sel changes take effect on the same cycle's grant computation. rr_ptr is not reset by a mode change.
- Reset asserted mid-transfer: the in-flight beat is discarded, outputs return to reset values immediately, and no in_ready is raised until reset deasserts.
- No combinational path from out_ready to out_data.

Test Plan (WIDTH=16, NUM_IN=8):
- Explicit select:
  - Stimulus: mode=0, out_ready=1, all in_valid=1, in_data = {CA88, 864A, 3AB4, 98E4, 1C3A, DC8D, 0D6B, 1736} (ch7..ch0), sweep sel 0..7.
  - Response: each following cycle out_valid=1, out_data equals in_data[sel] (e.g. sel=2 gives DC8D), out_src=sel. Repeat with inverted data.
- Round-robin fairness:
  - Stimulus: mode=1, all in_valid=1, out_ready=1 from reset.
  - Response: out_src sequence 0,1,2,...,7,0 on consecutive cycles, wrapping after 7.
- Sparse requests:
  - Stimulus: mode=1, in_valid = 8'b1000_0100, rr_ptr=2.
  - Response: grants ch7, then ch2, then ch7; in_ready one-hot matching each grant.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with out_valid=1.
  - Response: out_data and out_src stable, in_ready=0. When out_ready rises, a new beat loads on that same edge with no idle cycle.
- Invalid or absent select:
  - Stimulus: mode=0, sel=5 with in_valid[5]=0 (repeat with NUM_IN=6, sel=7).
  - Response: no in_ready asserted; out_valid drops to 0 after the current beat drains.
- Async reset mid-stream:
  - Stimulus: pull reset low between clock edges during a round-robin stream.
  - Response: out_valid=0, out_data=0, out_src=0 immediately. After release, the first grant goes to ch0.

Source files
------------

// File: rtl/bus_arb_mux_if.sv
// bus_arb_mux_if: producer-side request buses and the single registered consumer bus of bus_arb_mux.
interface bus_arb_mux_if #(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 8
);
   localparam int SELW = $clog2(NUM_IN);
   logic                         mode;
   logic [SELW-1:0]              sel;
   logic [NUM_IN-1:0][WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]            in_valid;
   logic [NUM_IN-1:0]            in_ready;
   logic [WIDTH-1:0]             out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [SELW-1:0]              out_src;
   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );
   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: N:1 bus mux, explicit-select or round-robin grant, registered output stage.
module bus_arb_mux #(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 8
) (
   input logic          clk,
   input logic          reset,
   bus_arb_mux_if.slave bus
);
   localparam int SELW = $clog2(NUM_IN);
   logic             load_en, gnt, accept;
   logic [SELW-1:0]  g, idx;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_src_q, out_src_d, rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   always_comb begin
      load_en = !out_valid_q || bus.out_ready;
      gnt     = 1'b0;
      g       = '0;
      idx     = '0;
      if (!bus.mode) begin
         gnt = (int'(bus.sel) < NUM_IN) && bus.in_valid[bus.sel];
         g   = bus.sel;
      end else begin
         // scan farthest-first so the nearest valid channel after rr_ptr wins
         for (int k = NUM_IN; k >= 1; k--) begin
            idx = SELW'((int'(rr_ptr_q) + k) % NUM_IN);
            if (bus.in_valid[idx]) begin
               gnt = 1'b1;
               g   = idx;
            end
         end
      end
      accept      = gnt && load_en;
      out_valid_d = load_en ? gnt : out_valid_q;
      out_data_d  = accept ? bus.in_data[g] : out_data_q;
      out_src_d   = accept ? g : out_src_q;
      rr_ptr_d    = accept ? g : rr_ptr_q;
   end
   assign bus.in_ready  = (accept && reset) ? NUM_IN'(1) << g : '0;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_src   = out_src_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= SELW'(NUM_IN - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end
endmodule

// File: tb/tb_bus_arb_mux.sv
// tb_bus_arb_mux: directed and randomized checks of bus_arb_mux against a priority-list reference model.
module tb_bus_arb_mux;
   logic clk, reset;
   int checks = 0, errors = 0;
   bus_arb_mux_if #(.WIDTH(16), .NUM_IN(8)) b ();
   bus_arb_mux_if #(.WIDTH(16), .NUM_IN(6)) b6 ();
   bus_arb_mux #(.WIDTH(16), .NUM_IN(8)) dut  (.clk(clk), .reset(reset), .bus(b.slave));
   bus_arb_mux #(.WIDTH(16), .NUM_IN(6)) dut6 (.clk(clk), .reset(reset), .bus(b6.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // reference state: the beat the consumer should see and the last granted channel
   logic        m_valid;
   logic [15:0] m_data;
   int          m_src, m_ptr;
   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 7;
   endtask
   function automatic void model_grant(output logic ok, output int g);
      ok = 1'b0;
      g  = 0;
      if (!b.mode) begin
         ok = b.in_valid[b.sel];
         g  = int'(b.sel);
      end else
         for (int k = 1; k <= 8 && !ok; k++)
            if (b.in_valid[3'((m_ptr + k) % 8)]) begin
               ok = 1'b1;
               g  = (m_ptr + k) % 8;
            end
   endfunction
   function automatic logic [7:0] exp_ready();
      logic ok;
      int   g;
      model_grant(ok, g);
      return (ok && (!m_valid || b.out_ready) && reset) ? 8'(1) << g : 8'h00;
   endfunction
   task automatic cycle();
      logic ok, ld;
      int   g;
      ld = !m_valid || b.out_ready;
      model_grant(ok, g);
      @(posedge clk);
      if (ld) begin
         m_valid = ok;
         if (ok) begin
            m_data = b.in_data[3'(g)];
            m_src  = g;
            m_ptr  = g;
         end
      end
      #1;
   endtask
   task automatic rand_data();
      for (int i = 0; i < 8; i++) b.in_data[i] = 16'($urandom);
   endtask
   task automatic test_reset();
      reset = 1'b0;
      b.mode = 1'b1; b.sel = '0; b.in_valid = '1; b.out_ready = 1'b1;
      b6.mode = 1'b0; b6.sel = '0; b6.in_valid = '0; b6.out_ready = 1'b1; b6.in_data = '0;
      rand_data();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", b.out_valid); end
      checks++; if (b.out_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0000", b.out_data); end
      checks++; if (b.out_src !== 3'd0) begin errors++; $display("FAIL rst_src got %0d want 0", b.out_src); end
      checks++; if (b.in_ready !== 8'h00) begin errors++; $display("FAIL rst_ready got %h want 00", b.in_ready); end
      reset = 1'b1;
      #1;
   endtask
   task automatic test_explicit();
      logic [7:0][15:0] tbl;
      tbl = {16'hCA88, 16'h864A, 16'h3AB4, 16'h98E4, 16'h1C3A, 16'hDC8D, 16'h0D6B, 16'h1736};
      b.mode = 1'b0; b.in_valid = '1; b.out_ready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         b.in_data = p == 0 ? tbl : ~tbl;
         for (int s = 0; s < 8; s++) begin
            b.sel = 3'(s);
            #1;
            checks++; if (b.in_ready !== 8'(1) << s) begin errors++; $display("FAIL expl_ready sel %0d got %h want %h", s, b.in_ready, 8'(1) << s); end
            cycle();
            checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL expl_valid sel %0d got %0b want 1", s, b.out_valid); end
            checks++; if (b.out_data !== (p == 0 ? tbl[s] : ~tbl[s])) begin errors++; $display("FAIL expl_data sel %0d got %h want %h", s, b.out_data, p == 0 ? tbl[s] : ~tbl[s]); end
            checks++; if (b.out_src !== 3'(s)) begin errors++; $display("FAIL expl_src got %0d want %0d", b.out_src, s); end
         end
      end
   endtask
   task automatic test_rr_fair();
      reset = 1'b0;
      #2;
      model_reset();
      b.mode = 1'b1; b.in_valid = '1; b.out_ready = 1'b1;
      reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rand_data();
         cycle();
         checks++; if (b.out_src !== 3'(i % 8)) begin errors++; $display("FAIL rr_src step %0d got %0d want %0d", i, b.out_src, i % 8); end
         checks++; if (b.out_data !== m_data || b.out_valid !== 1'b1) begin errors++; $display("FAIL rr_data got %h/%0b want %h/1", b.out_data, b.out_valid, m_data); end
      end
   endtask
   task automatic test_sparse();
      int exp_g[3] = '{7, 2, 7};
      b.mode = 1'b0; b.sel = 3'd2; b.in_valid = '1; b.out_ready = 1'b1;
      cycle();
      b.mode = 1'b1; b.in_valid = 8'b1000_0100;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         #1;
         checks++; if (b.in_ready !== 8'(1) << exp_g[i]) begin errors++; $display("FAIL sparse_ready step %0d got %h want %h", i, b.in_ready, 8'(1) << exp_g[i]); end
         cycle();
         checks++; if (b.out_src !== 3'(exp_g[i]) || b.out_data !== m_data) begin errors++; $display("FAIL sparse_out step %0d got %0d/%h want %0d/%h", i, b.out_src, b.out_data, exp_g[i], m_data); end
      end
   endtask
   task automatic test_backpressure();
      logic [15:0] d;
      logic [2:0]  s;
      b.mode = 1'b1; b.in_valid = '1; b.out_ready = 1'b1;
      rand_data();
      cycle();
      d = b.out_data;
      s = b.out_src;
      b.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         #1;
         checks++; if (b.in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready cyc %0d got %h want 00", i, b.in_ready); end
         cycle();
         checks++; if (b.out_data !== d || b.out_src !== s || b.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got %h/%0d/%0b want %h/%0d/1", i, b.out_data, b.out_src, b.out_valid, d, s); end
      end
      b.out_ready = 1'b1;
      #1;
      checks++; if (b.in_ready !== 8'(1) << ((s + 3'd1) % 8)) begin errors++; $display("FAIL bp_release_ready got %h want %h", b.in_ready, 8'(1) << ((s + 3'd1) % 8)); end
      cycle();
      checks++; if (b.out_valid !== 1'b1 || b.out_src !== 3'(s + 3'd1) || b.out_data !== m_data) begin errors++; $display("FAIL bp_release_out got %0b/%0d/%h want 1/%0d/%h", b.out_valid, b.out_src, b.out_data, 3'(s + 3'd1), m_data); end
   endtask
   task automatic test_no_grant();
      b.mode = 1'b0; b.sel = 3'd5; b.in_valid = 8'hDF; b.out_ready = 1'b1;
      #1;
      checks++; if (b.in_ready !== 8'h00) begin errors++; $display("FAIL nogrant_ready got %h want 00", b.in_ready); end
      cycle();
      checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL nogrant_valid got %0b want 0", b.out_valid); end
      for (int i = 0; i < 6; i++) b6.in_data[i] = 16'($urandom);
      b6.mode = 1'b0; b6.sel = 3'd3; b6.in_valid = 6'h3F;
      cycle();
      checks++; if (b6.out_valid !== 1'b1 || b6.out_src !== 3'd3 || b6.out_data !== b6.in_data[3]) begin errors++; $display("FAIL n6_beat got %0b/%0d/%h want 1/3/%h", b6.out_valid, b6.out_src, b6.out_data, b6.in_data[3]); end
      b6.sel = 3'd7;
      #1;
      checks++; if (b6.in_ready !== 6'h00) begin errors++; $display("FAIL n6_ready got %h want 00", b6.in_ready); end
      cycle();
      checks++; if (b6.out_valid !== 1'b0) begin errors++; $display("FAIL n6_valid got %0b want 0", b6.out_valid); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         b.mode = 1'($urandom);
         b.sel = 3'($urandom);
         b.in_valid = 8'($urandom) & 8'($urandom);
         b.out_ready = $urandom_range(0, 3) != 0;
         rand_data();
         #1;
         checks++; if (b.in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready it %0d got %h want %h", i, b.in_ready, exp_ready()); end
         cycle();
         checks++; if (b.out_valid !== m_valid || (m_valid && (b.out_data !== m_data || b.out_src !== 3'(m_src)))) begin errors++; $display("FAIL rand_out it %0d got %0b/%h/%0d want %0b/%h/%0d", i, b.out_valid, b.out_data, b.out_src, m_valid, m_data, m_src); end
      end
   endtask
   task automatic test_async_reset();
      b.mode = 1'b1; b.in_valid = '1; b.out_ready = 1'b1;
      repeat (3) begin
         rand_data();
         cycle();
      end
      checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %0b want 1", b.out_valid); end
      #2 reset = 1'b0;
      #1;
      checks++; if (b.out_valid !== 1'b0 || b.out_data !== 16'h0 || b.out_src !== 3'd0) begin errors++; $display("FAIL ar_outputs got %0b/%h/%0d want 0/0000/0", b.out_valid, b.out_data, b.out_src); end
      checks++; if (b.in_ready !== 8'h00) begin errors++; $display("FAIL ar_ready got %h want 00", b.in_ready); end
      model_reset();
      @(posedge clk);
      #1;
      checks++; if (b.in_ready !== 8'h00 || b.out_valid !== 1'b0) begin errors++; $display("FAIL ar_held got %h/%0b want 00/0", b.in_ready, b.out_valid); end
      #1 reset = 1'b1;
      #1;
      checks++; if (b.in_ready !== 8'h01) begin errors++; $display("FAIL ar_first_ready got %h want 01", b.in_ready); end
      cycle();
      checks++; if (b.out_valid !== 1'b1 || b.out_src !== 3'd0 || b.out_data !== b.in_data[0]) begin errors++; $display("FAIL ar_first_beat got %0b/%0d/%h want 1/0/%h", b.out_valid, b.out_src, b.out_data, b.in_data[0]); end
   endtask
   initial begin
      test_reset();
      test_explicit();
      test_rr_fair();
      test_sparse();
      test_backpressure();
      test_no_grant();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
